store_buffer_aligner: RTL and testbench

- Store-side counterpart of the MEM-stage load extender.
- Accepts sb/sh/sw from the MEM stage and checks alignment.
- Produces word address, byte enables and lane-replicated write data.
- Queues writes in a small FIFO and drains it to data memory through a req/gnt handshake, so memory wait states do not stall the pipeline until the buffer fills.
- Flags pending-store address matches so the hazard unit can stall younger loads.

---
 rtl/mips_defs.sv | 26 ++
 rtl/store_lane_encode.sv | 44 ++++
 rtl/store_buffer_aligner.sv | 104 ++++++++++
 tb/tb_store_buffer_aligner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory opcodes, byte-enable width and the
// store-buffer entry layout used by the store path.
package mips_defs;

    // Load opcodes (used by the MEM-stage load extender)
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // Store opcodes
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int BE_W = 4;

    // One buffered write: word address, byte enables, lane-replicated data
    typedef struct packed {
        logic [29:0]     addr;
        logic [BE_W-1:0] be;
        logic [31:0]     data;
    } store_entry_t;

endpackage

// File: rtl/store_lane_encode.sv
// Combinational store lane encoder: turns opcode, low address bits and the
// unaligned rt value into byte enables, lane-replicated data and a
// misalignment flag. Store-side mirror of the load extender.
module store_lane_encode
    import mips_defs::*;
(
    input  logic [5:0]      opcode,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    output logic            is_store,
    output logic [BE_W-1:0] be,
    output logic [31:0]     data,
    output logic            misaligned
);

    // Decode the store size and place the data on the addressed lanes
    always_comb begin
        is_store   = 1'b0;
        be         = '0;
        data       = '0;
        misaligned = 1'b0;
        case (opcode)
            OP_SB: begin
                is_store = 1'b1;
                be       = 4'b0001 << addr_lo;
                data     = {4{wdata[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                data       = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            OP_SW: begin
                is_store   = 1'b1;
                be         = 4'b1111;
                data       = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer_aligner.sv
// Store buffer with alignment check: encodes MEM-stage stores, queues them
// in a small FIFO and drains them to data memory over a req/gnt handshake.
// Also reports pending-store word matches for load hazard detection.
module store_buffer_aligner
    import mips_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      ir_m,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             exc_ades,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic [31:0]      mem_addr,
    output logic [BE_W-1:0]  mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    store_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic             exc_q;

    logic             is_store;
    logic             misaligned;
    logic [BE_W-1:0]  enc_be;
    logic [31:0]      enc_data;
    logic             push;
    logic             pop;

    // Only the opcode field and the word part of the load address matter
    logic             unused_bits;
    assign unused_bits = ^{ir_m[25:0], ld_addr[1:0]};

    store_lane_encode u_encode (
        .opcode     (ir_m[31:26]),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .is_store   (is_store),
        .be         (enc_be),
        .data       (enc_data),
        .misaligned (misaligned)
    );

    assign st_ready  = (count_q != CNT_W'(DEPTH));
    assign mem_req   = (count_q != '0);
    assign push      = st_valid & st_ready & is_store & ~misaligned;
    assign pop       = mem_req & mem_gnt;
    assign mem_addr  = {entries[head].addr, 2'b00};
    assign mem_be    = entries[head].be;
    assign mem_wdata = entries[head].data;
    assign exc_ades  = exc_q;
    assign count     = count_q;

    // FIFO storage, pointers, occupancy and the registered address-error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            exc_q <= st_valid & is_store & misaligned;
            if (push) begin
                entries[tail] <= '{addr: addr[31:2], be: enc_be, data: enc_data};
                valid[tail]   <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Any buffered store to the same word as the load in MEM is a hazard
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer_aligner.sv
// Self-checking bench for store_buffer_aligner: directed scenarios plus a
// scoreboard that predicts each memory write when the store is accepted.
module tb_store_buffer_aligner;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] ir_m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exc_ades;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_write_t;

    exp_write_t sb_q[$];
    int num_checks = 0;
    int num_fails  = 0;

    always #5 clk = ~clk;

    store_buffer_aligner #(.DEPTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .ir_m      (ir_m),
        .addr      (addr),
        .wdata     (wdata),
        .exc_ades  (exc_ades),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .count     (count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference lane model written from the instruction-set view
    function automatic void laneModel(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                      output logic st, output logic mis, output exp_write_t w);
        st  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        mis = 1'b0;
        w.addr = {a[31:2], 2'b00};
        w.be   = 4'b0000;
        w.data = 32'h0;
        if (op == OP_SB) begin
            case (a[1:0])
                2'd0: w.be = 4'b0001;
                2'd1: w.be = 4'b0010;
                2'd2: w.be = 4'b0100;
                default: w.be = 4'b1000;
            endcase
            w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end else if (op == OP_SH) begin
            mis    = a[0];
            w.be   = a[1] ? 4'b1100 : 4'b0011;
            w.data = {d[15:0], d[15:0]};
        end else if (op == OP_SW) begin
            mis    = (a[1:0] != 2'b00);
            w.be   = 4'b1111;
            w.data = d;
        end
    endfunction

    // Scoreboard: compare each granted write, then record any store accepted this cycle
    always @(negedge clk) begin
        logic st, mis;
        exp_write_t w, e;
        if (reset) begin
            if (mem_req && mem_gnt) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("wr_addr", mem_addr, e.addr);
                    checkOutput("wr_be", {28'h0, mem_be}, {28'h0, e.be});
                    checkOutput("wr_data", mem_wdata, e.data);
                end
            end
            laneModel(ir_m[31:26], addr, wdata, st, mis, w);
            if (st_valid && st_ready && st && !mis)
                sb_q.push_back(w);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        ir_m     = {op, 26'h0};
        addr     = a;
        wdata    = d;
    endtask

    task automatic idle();
        st_valid = 1'b0;
        ir_m     = 32'h0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        mem_gnt = 1'b1;
        while (count != 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, {29'h0, count}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; ir_m = 32'h0; addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; ld_addr = 32'h0;
        #12;
        checkOutput("rst_count", {29'h0, count}, 32'd0);
        checkOutput("rst_req", {31'h0, mem_req}, 32'd0);
        checkOutput("rst_ready", {31'h0, st_ready}, 32'd1);
        checkOutput("rst_exc", {31'h0, exc_ades}, 32'd0);
        checkOutput("rst_hit", {31'h0, ld_hit}, 32'd0);
        checkOutput("rst_maddr", mem_addr, 32'h0);
        checkOutput("rst_mbe", {28'h0, mem_be}, 32'h0);
        checkOutput("rst_mdata", mem_wdata, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // sb to the top byte lane, granted immediately
        mem_gnt = 1'b1;
        applyStimulus(OP_SB, 32'h0000_1003, 32'h0000_00AB);
        tick();
        idle();
        checkOutput("sb_req", {31'h0, mem_req}, 32'd1);
        checkOutput("sb_addr", mem_addr, 32'h0000_1000);
        checkOutput("sb_be", {28'h0, mem_be}, 32'b1000);
        checkOutput("sb_data", mem_wdata, 32'hABAB_ABAB);
        tick();
        checkOutput("sb_count_after", {29'h0, count}, 32'd0);

        // sh to upper half, then a misaligned sh and a misaligned non-store
        applyStimulus(OP_SH, 32'h0000_2002, 32'h0000_1234);
        tick();
        idle();
        checkOutput("sh_be", {28'h0, mem_be}, 32'b1100);
        checkOutput("sh_data", mem_wdata, 32'h1234_1234);
        tick();
        applyStimulus(OP_SH, 32'h0000_2001, 32'h0000_5678);
        tick();
        idle();
        checkOutput("ades_pulse", {31'h0, exc_ades}, 32'd1);
        checkOutput("ades_count", {29'h0, count}, 32'd0);
        checkOutput("ades_req", {31'h0, mem_req}, 32'd0);
        tick();
        checkOutput("ades_clear", {31'h0, exc_ades}, 32'd0);
        applyStimulus(OP_LW, 32'h0000_2003, 32'h0);
        tick();
        idle();
        checkOutput("nonstore_exc", {31'h0, exc_ades}, 32'd0);
        checkOutput("nonstore_count", {29'h0, count}, 32'd0);

        // Fill with gnt low, fifth store held until a slot opens
        mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_SW, 32'h0000_4000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            if (i < 4) tick();
        end
        checkOutput("full_count", {29'h0, count}, 32'd4);
        checkOutput("full_ready", {31'h0, st_ready}, 32'd0);
        tick();
        checkOutput("full_held", {29'h0, count}, 32'd4);
        mem_gnt = 1'b1;
        tick();
        checkOutput("full_pop_no_push", {29'h0, count}, 32'd3);
        tick();
        idle();
        checkOutput("fifth_accepted", {29'h0, count}, 32'd3);
        drain("full_drain");

        // Steady push+pop at count=2 across the pointer wrap
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [5:0] op;
            op = (i % 3 == 0) ? OP_SB : ((i % 3 == 1) ? OP_SH : OP_SW);
            if (i == 2) mem_gnt = 1'b1;
            applyStimulus(op, 32'h0000_5000 + 32'(i * 8) + ((op == OP_SB) ? 32'(i % 4) : 32'h0), $urandom);
            tick();
            if (i >= 1) checkOutput("wrap_count", {29'h0, count}, 32'd2);
        end
        idle();
        drain("wrap_drain");

        // Load hazard detection
        mem_gnt = 1'b0;
        ld_addr = 32'h0000_3000;
        applyStimulus(OP_SW, 32'h0000_3000, 32'hDEAD_BEEF);
        #1;
        checkOutput("hit_accepting", {31'h0, ld_hit}, 32'd0);
        tick();
        idle();
        ld_addr = 32'h0000_3002;
        #1;
        checkOutput("hit_same_word", {31'h0, ld_hit}, 32'd1);
        ld_addr = 32'h0000_3004;
        #1;
        checkOutput("hit_next_word", {31'h0, ld_hit}, 32'd0);
        ld_addr = 32'h0000_3002;
        mem_gnt = 1'b1;
        #1;
        checkOutput("hit_granting", {31'h0, ld_hit}, 32'd1);
        tick();
        checkOutput("hit_after_pop", {31'h0, ld_hit}, 32'd0);

        // Reset while three writes are pending
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_SW, 32'h0000_6000 + 32'(i * 4), 32'h6000_0000 + 32'(i));
            tick();
        end
        idle();
        checkOutput("pre_rst_count", {29'h0, count}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        checkOutput("async_req", {31'h0, mem_req}, 32'd0);
        checkOutput("async_count", {29'h0, count}, 32'd0);
        tick();
        reset = 1'b1;
        mem_gnt = 1'b1;
        tick();
        checkOutput("post_rst_ready", {31'h0, st_ready}, 32'd1);
        tick();
        tick();
        checkOutput("post_rst_req", {31'h0, mem_req}, 32'd0);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
